// File: rtl/kmp_fail_gen_if.sv
// ---------------------------------------------------------------------------
// kmp_fail_gen_if
//
// Bundles the request/result signals of the KMP failure-function generator.
//
//   start         master -> slave   one-cycle build request
//   pat_reg       master -> slave   packed pattern, char i at [(MAX_PATTERN-1-i)*BYTE +: BYTE]
//   pat_last_idx  master -> slave   index of the last valid pattern char (length-1)
//   busy          slave  -> master  high while the table is being built
//   done          slave  -> master  one-cycle completion pulse
//   ff_valid      slave  -> master  table valid, held until the next accepted start
//   ff_result     slave  -> master  packed table, entry i at [(MAX_PATTERN-1-i)*MAX_PAT_ADD +: MAX_PAT_ADD]
// ---------------------------------------------------------------------------
interface kmp_fail_gen_if #(
    parameter int BYTE        = 8,
    parameter int MAX_PATTERN = 8,
    parameter int MAX_PAT_ADD = 3
);
    logic                               start;
    logic [MAX_PATTERN*BYTE-1:0]        pat_reg;
    logic [MAX_PAT_ADD-1:0]             pat_last_idx;
    logic                               busy;
    logic                               done;
    logic                               ff_valid;
    logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result;

    modport master (
        output start, pat_reg, pat_last_idx,
        input  busy, done, ff_valid, ff_result
    );

    modport slave (
        input  start, pat_reg, pat_last_idx,
        output busy, done, ff_valid, ff_result
    );
endinterface

// File: rtl/kmp_fail_gen.sv
// ---------------------------------------------------------------------------
// kmp_fail_gen
//
// Sequential KMP failure-function (prefix-table) generator. After a start
// request it walks the pattern one prefix-table step per cycle and then
// presents the packed failure table used by the KMP processing elements.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset
//   bus    kmp_fail_gen_if.slave: start / pat_reg / pat_last_idx in,
//          busy / done / ff_valid / ff_result out
//
// The pattern inputs are not latched; they must stay stable from start
// until done.
// ---------------------------------------------------------------------------
module kmp_fail_gen #(
    parameter int BYTE        = 8,
    parameter int MAX_PATTERN = 8,
    parameter int MAX_PAT_ADD = 3
) (
    input  logic           clk,
    input  logic           reset,
    kmp_fail_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        COMPARE,
        DONE_ST
    } state_t;

    // i carries one extra bit so that stepping past the last index never wraps.
    localparam logic [MAX_PAT_ADD:0] IDX_ONE = 1;

    state_t                 state_q;
    logic [MAX_PAT_ADD:0]   i_q;
    logic [MAX_PAT_ADD-1:0] k_q;
    logic [MAX_PAT_ADD-1:0] fail_q [MAX_PATTERN];
    logic                   busy_q;
    logic                   done_q;
    logic                   valid_q;

    logic [BYTE-1:0]        pat_chars [MAX_PATTERN];
    logic [MAX_PAT_ADD-1:0] i_idx;
    logic                   char_match;
    logic                   last_step;

    // Unpack the pattern so characters can be addressed by index.
    always_comb begin
        for (int c = 0; c < MAX_PATTERN; c++) begin
            pat_chars[c] = bus.pat_reg[(MAX_PATTERN-1-c)*BYTE +: BYTE];
        end
    end

    // While comparing, i never exceeds pat_last_idx, so its low bits address a char.
    assign i_idx      = i_q[MAX_PAT_ADD-1:0];
    assign char_match = (pat_chars[i_idx] == pat_chars[k_q]);
    // True when an advance of i in this cycle moves it past the last index.
    assign last_step  = (i_q == {1'b0, bus.pat_last_idx});

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples pre-edge values; mixing in blocking writes would make
    // the result depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= IDX_ONE;
            k_q     <= '0;
            // NOTE: the fail table is a small flop array, not a RAM, and it
            // drives ff_result directly, so it is reset to give a defined
            // all-zero result after reset.
            for (int e = 0; e < MAX_PATTERN; e++) begin
                fail_q[e] <= '0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= INIT;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end

                INIT: begin
                    for (int e = 0; e < MAX_PATTERN; e++) begin
                        fail_q[e] <= '0;
                    end
                    i_q <= IDX_ONE;
                    k_q <= '0;
                    if (bus.pat_last_idx == '0) begin
                        // Single-character pattern: fail[0] is 0 by definition.
                        state_q <= DONE_ST;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= COMPARE;
                    end
                end

                COMPARE: begin
                    if (char_match) begin
                        fail_q[i_idx] <= k_q + 1'b1;
                        k_q           <= k_q + 1'b1;
                        i_q           <= i_q + 1'b1;
                    end else if (k_q != '0) begin
                        // Fall back to the next shorter border; i stays put.
                        k_q <= fail_q[k_q - 1'b1];
                    end else begin
                        fail_q[i_idx] <= '0;
                        i_q           <= i_q + 1'b1;
                    end

                    // Only the two branches that advance i can finish the table.
                    if ((char_match || (k_q == '0)) && last_step) begin
                        state_q <= DONE_ST;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end

                DONE_ST: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= INIT;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the packed result gets a full default before the loop so no
    // bit is left unassigned on any path, which would infer a latch.
    always_comb begin
        bus.ff_result = '0;
        for (int e = 0; e < MAX_PATTERN; e++) begin
            bus.ff_result[(MAX_PATTERN-1-e)*MAX_PAT_ADD +: MAX_PAT_ADD] = fail_q[e];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ff_valid = valid_q;

endmodule
